// File: rtl/fft_pkg.sv
// Shared FFT types: complex sample, ping-pong bank state, and the index bit-reversal helper.
package fft_pkg;

  localparam int FFT_DATA_W = 16;
  localparam int MAX_LOG2_N = 10;

  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Reverses the low log2_n bits of value; bits at and above log2_n come back as zero.
  function automatic logic [MAX_LOG2_N-1:0] bitrev(input logic [MAX_LOG2_N-1:0] value,
                                                   input int log2_n);
    logic [MAX_LOG2_N-1:0] r;
    logic [3:0]            src;
    r = '0;
    for (int i = 0; i < MAX_LOG2_N; i++) begin
      if (i < log2_n) begin
        src  = 4'(log2_n - 1 - i);
        r[i] = value[src];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_bank.sv
// One frame-sized register bank: synchronous write port, asynchronous read port.
module bitrev_bank
  import fft_pkg::*;
#(
  parameter int N_POINTS = 64,
  parameter int LOG2_N   = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LOG2_N-1:0] wr_addr,
  input  cplx_t             wr_data,
  input  logic [LOG2_N-1:0] rd_addr,
  output cplx_t             rd_data
);

  cplx_t mem [N_POINTS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_bitrev_router.sv
// Ping-pong frame buffer that reorders natural-order samples into bit-reversed order.
// Optional macro STREAM_BITREV_BYPASS_EN adds a per-frame bypass input (natural-order output).
module stream_bitrev_router
  import fft_pkg::*;
#(
  parameter int N_POINTS = 64,
  parameter int LOG2_N   = 6,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_last
`ifdef STREAM_BITREV_BYPASS_EN
  ,
  input  logic              bypass
`endif
);

  // The sample struct is shared through fft_pkg, so its width fixes DATA_W.
  if ((N_POINTS != (1 << LOG2_N)) || (LOG2_N < 2) || (LOG2_N > MAX_LOG2_N) ||
      (DATA_W != FFT_DATA_W)) begin : g_param_check
    $error("stream_bitrev_router: N_POINTS must equal 2**LOG2_N (4..1024) and DATA_W must equal FFT_DATA_W");
  end

  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_POINTS - 1);

  logic              wr_bank;
  logic              rd_bank;
  logic [LOG2_N-1:0] wr_cnt;
  logic [LOG2_N-1:0] rd_cnt;
  bank_state_t       bank_state [2];

  logic              in_fire;
  logic              out_fire;
  logic              wr_last;
  logic [LOG2_N-1:0] rev_addr;
  logic [LOG2_N-1:0] rd_addr;
  cplx_t             wr_data;
  cplx_t             rd_data [2];
  cplx_t             rd_sel;

  assign in_ready  = !rst && (bank_state[wr_bank] != BANK_FULL);
  assign out_valid = !rst && (bank_state[rd_bank] == BANK_FULL);
  assign out_last  = out_valid && (rd_cnt == LAST_IDX);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wr_last   = (wr_cnt == LAST_IDX);

  assign rev_addr  = LOG2_N'(bitrev(MAX_LOG2_N'(rd_cnt), LOG2_N));

`ifdef STREAM_BITREV_BYPASS_EN
  // Bypass travels with the bank: latched on the first beat, consulted while that bank drains.
  logic bank_bypass [2];

  always_ff @(posedge clk) begin
    if (in_fire && (wr_cnt == '0)) bank_bypass[wr_bank] <= bypass;
  end

  assign rd_addr = bank_bypass[rd_bank] ? rd_cnt : rev_addr;
`else
  assign rd_addr = rev_addr;
`endif

  assign wr_data = {in_re, in_im};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    bitrev_bank #(
      .N_POINTS(N_POINTS),
      .LOG2_N  (LOG2_N)
    ) u_bank (
      .clk    (clk),
      .wr_en  (in_fire && (wr_bank == 1'(b))),
      .wr_addr(wr_cnt),
      .wr_data(wr_data),
      .rd_addr(rd_addr),
      .rd_data(rd_data[b])
    );
  end

  assign rd_sel = rd_data[rd_bank];
  assign out_re = rd_sel.re;
  assign out_im = rd_sel.im;

  // Write and read always target different banks, so both updates can land on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
    end else begin
      if (in_fire) begin
        if (wr_last) begin
          bank_state[wr_bank] <= BANK_FULL;
          wr_bank             <= ~wr_bank;
          wr_cnt              <= '0;
        end else begin
          bank_state[wr_bank] <= BANK_FILLING;
          wr_cnt              <= wr_cnt + 1'b1;
        end
      end
      if (out_fire) begin
        if (rd_cnt == LAST_IDX) begin
          bank_state[rd_bank] <= BANK_EMPTY;
          rd_bank             <= ~rd_bank;
          rd_cnt              <= '0;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_bitrev_router.sv
// Bench for stream_bitrev_router: random frames scored against a queue-based reorder model.
module tb_stream_bitrev_router;

  localparam int N    = 64;
  localparam int LOG2 = 6;
  localparam int DW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_im = '0;
  logic          in_ready, out_valid, out_last;
  logic [DW-1:0] out_re, out_im;
`ifdef STREAM_BITREV_BYPASS_EN
  logic          bypass = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [DW-1:0] obs_re[$], obs_im[$], exp_re[$], exp_im[$];
  bit            obs_last[$], exp_last[$];
  int            obs_cyc[$], in_cyc[$];

  stream_bitrev_router #(.N_POINTS(N), .LOG2_N(LOG2), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_last (out_last)
`ifdef STREAM_BITREV_BYPASS_EN
    ,
    .bypass   (bypass)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every handshake that will complete on the coming rising edge.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) in_cyc.push_back(cyc);
    if (!rst && out_valid && out_ready) begin
      obs_re.push_back(out_re);
      obs_im.push_back(out_im);
      obs_last.push_back(out_last);
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int bitrev_ref(input int k);
    int r = 0;
    int x = k;
    for (int b = 0; b < LOG2; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  task automatic clear_queues();
    obs_re.delete(); obs_im.delete(); obs_last.delete(); obs_cyc.delete();
    exp_re.delete(); exp_im.delete(); exp_last.delete(); in_cyc.delete();
  endtask

  task automatic push_beat(input logic [DW-1:0] re, input logic [DW-1:0] im, input bit byp);
    bit acc = 0;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
`ifdef STREAM_BITREV_BYPASS_EN
    bypass   = byp;
`endif
    for (int w = 0; w < 3000 && !acc; w++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Drives one frame and appends the order the frame must come out in.
  task automatic send_frame(input logic [DW-1:0] fre [N], input logic [DW-1:0] fim [N],
                            input bit byp, input int max_gap);
    bit natural;
    int idx;
    for (int k = 0; k < N; k++) begin
      push_beat(fre[k], fim[k], (k == 0) ? byp : 1'($urandom));
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
    end
`ifdef STREAM_BITREV_BYPASS_EN
    natural = byp;
`else
    natural = 1'b0;
`endif
    for (int j = 0; j < N; j++) begin
      idx = natural ? j : bitrev_ref(j);
      exp_re.push_back(fre[idx]);
      exp_im.push_back(fim[idx]);
      exp_last.push_back(j == N - 1);
    end
  endtask

  task automatic wait_drain(input int n);
    for (int c = 0; c < 4000 && obs_re.size() < n; c++) begin
      @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic rand_frame(output logic [DW-1:0] fre [N], output logic [DW-1:0] fim [N]);
    for (int k = 0; k < N; k++) begin
      fre[k] = DW'($urandom);
      fim[k] = DW'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] fre [N];
    logic [DW-1:0] fim [N];
    int lasts = 0;
    clear_queues();
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin fre[k] = DW'(k); fim[k] = DW'(k); end
    send_frame(fre, fim, 1'b0, 0);
    wait_drain(N);
    n_cmp++; if (obs_re.size() !== N) begin n_fail++; $display("FAIL single_count: got %0d want %0d", obs_re.size(), N); end
    for (int i = 0; i < exp_re.size() && i < obs_re.size(); i++) begin
      n_cmp++;
      if ({obs_re[i], obs_im[i], obs_last[i]} !== {exp_re[i], exp_im[i], exp_last[i]}) begin
        n_fail++;
        $display("FAIL single_beat[%0d]: got re=%0d im=%0d last=%0d want re=%0d im=%0d last=%0d",
                 i, obs_re[i], obs_im[i], obs_last[i], exp_re[i], exp_im[i], exp_last[i]);
      end
    end
    if (obs_re.size() >= N) begin
      n_cmp++; if ({obs_re[1], obs_re[2], obs_re[3], obs_re[4]} !== {16'd32, 16'd16, 16'd48, 16'd8}) begin
        n_fail++; $display("FAIL single_order_head: got %0d,%0d,%0d,%0d want 32,16,48,8", obs_re[1], obs_re[2], obs_re[3], obs_re[4]);
      end
      n_cmp++; if ({obs_last[N-1], obs_re[N-1]} !== {1'b1, 16'd63}) begin
        n_fail++; $display("FAIL single_last_beat: got last=%0d re=%0d want last=1 re=63", obs_last[N-1], obs_re[N-1]);
      end
      foreach (obs_last[i]) lasts += int'(obs_last[i]);
      n_cmp++; if (lasts !== 1) begin n_fail++; $display("FAIL single_last_count: got %0d want 1", lasts); end
      n_cmp++; if (obs_cyc[0] - in_cyc[0] + 1 !== N + 1) begin
        n_fail++; $display("FAIL single_latency: got %0d want %0d", obs_cyc[0] - in_cyc[0] + 1, N + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] fre [N];
    logic [DW-1:0] fim [N];
    int in_gaps = 0;
    int out_gaps = 0;
    clear_queues();
    out_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rand_frame(fre, fim);
      send_frame(fre, fim, 1'b0, 0);
    end
    wait_drain(3 * N);
    n_cmp++; if (obs_re.size() !== 3 * N) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", obs_re.size(), 3 * N); end
    for (int i = 0; i < exp_re.size() && i < obs_re.size(); i++) begin
      n_cmp++;
      if ({obs_re[i], obs_im[i], obs_last[i]} !== {exp_re[i], exp_im[i], exp_last[i]}) begin
        n_fail++;
        $display("FAIL b2b_beat[%0d]: got re=%0d im=%0d last=%0d want re=%0d im=%0d last=%0d",
                 i, obs_re[i], obs_im[i], obs_last[i], exp_re[i], exp_im[i], exp_last[i]);
      end
    end
    for (int i = 1; i < in_cyc.size(); i++) if (in_cyc[i] != in_cyc[i-1] + 1) in_gaps++;
    for (int i = 1; i < obs_cyc.size(); i++) if (obs_cyc[i] != obs_cyc[i-1] + 1) out_gaps++;
    n_cmp++; if (in_gaps !== 0) begin n_fail++; $display("FAIL b2b_input_bubbles: got %0d want 0", in_gaps); end
    n_cmp++; if (out_gaps !== 0) begin n_fail++; $display("FAIL b2b_output_bubbles: got %0d want 0", out_gaps); end
    if (obs_cyc.size() > 0 && in_cyc.size() > 0) begin
      n_cmp++; if (obs_cyc[0] - in_cyc[0] + 1 !== N + 1) begin
        n_fail++; $display("FAIL b2b_latency: got %0d want %0d", obs_cyc[0] - in_cyc[0] + 1, N + 1);
      end
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] sre [3][N];
    logic [DW-1:0] sim [3][N];
    clear_queues();
    out_ready = 1'b0;
    for (int f = 0; f < 3; f++) rand_frame(sre[f], sim[f]);
    fork
      begin
        for (int f = 0; f < 3; f++) send_frame(sre[f], sim[f], 1'b0, 0);
      end
      begin
        for (int c = 0; c < 1000 && in_cyc.size() < 2 * N; c++) @(negedge clk);
        repeat (8) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid: got %b want 1", out_valid); end
        n_cmp++; if (in_cyc.size() !== 2 * N) begin n_fail++; $display("FAIL stall_accepted: got %0d want %0d", in_cyc.size(), 2 * N); end
        n_cmp++; if (out_re !== sre[0][0]) begin n_fail++; $display("FAIL stall_head: got %0d want %0d", out_re, sre[0][0]); end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain(3 * N);
    n_cmp++; if (obs_re.size() !== 3 * N) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", obs_re.size(), 3 * N); end
    for (int i = 0; i < exp_re.size() && i < obs_re.size(); i++) begin
      n_cmp++;
      if ({obs_re[i], obs_im[i], obs_last[i]} !== {exp_re[i], exp_im[i], exp_last[i]}) begin
        n_fail++;
        $display("FAIL stall_beat[%0d]: got re=%0d im=%0d last=%0d want re=%0d im=%0d last=%0d",
                 i, obs_re[i], obs_im[i], obs_last[i], exp_re[i], exp_im[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [DW-1:0] fre [N];
    logic [DW-1:0] fim [N];
    int valid_seen = 0;
    clear_queues();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) push_beat(DW'($urandom), DW'($urandom), 1'b0);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) valid_seen++;
    end
    @(posedge clk); #1;
    n_cmp++; if (valid_seen !== 0) begin n_fail++; $display("FAIL midreset_out_valid: got %0d cycles want 0", valid_seen); end
    rand_frame(fre, fim);
    send_frame(fre, fim, 1'b0, 0);
    wait_drain(N);
    n_cmp++; if (obs_re.size() !== N) begin n_fail++; $display("FAIL midreset_count: got %0d want %0d", obs_re.size(), N); end
    for (int i = 0; i < exp_re.size() && i < obs_re.size(); i++) begin
      n_cmp++;
      if ({obs_re[i], obs_im[i], obs_last[i]} !== {exp_re[i], exp_im[i], exp_last[i]}) begin
        n_fail++;
        $display("FAIL midreset_beat[%0d]: got re=%0d im=%0d last=%0d want re=%0d im=%0d last=%0d",
                 i, obs_re[i], obs_im[i], obs_last[i], exp_re[i], exp_im[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_toggle_ready();
    logic [DW-1:0] fre [N];
    logic [DW-1:0] fim [N];
    clear_queues();
    out_ready = 1'b0;
    fork
      begin
        for (int f = 0; f < 2; f++) begin
          rand_frame(fre, fim);
          send_frame(fre, fim, 1'b0, 2);
        end
      end
      begin
        bit            held = 0;
        logic [DW-1:0] h_re, h_im;
        logic          h_last;
        for (int c = 0; c < 3000 && obs_re.size() < 2 * N; c++) begin
          @(negedge clk);
          if (held) begin
            n_cmp++;
            if ({out_valid, out_re, out_im, out_last} !== {1'b1, h_re, h_im, h_last}) begin
              n_fail++;
              $display("FAIL toggle_hold: got v=%b re=%0d im=%0d last=%b want v=1 re=%0d im=%0d last=%b",
                       out_valid, out_re, out_im, out_last, h_re, h_im, h_last);
            end
          end
          held   = out_valid && !out_ready;
          h_re   = out_re;
          h_im   = out_im;
          h_last = out_last;
          @(posedge clk); #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(2 * N);
    n_cmp++; if (obs_re.size() !== 2 * N) begin n_fail++; $display("FAIL toggle_count: got %0d want %0d", obs_re.size(), 2 * N); end
    for (int i = 0; i < exp_re.size() && i < obs_re.size(); i++) begin
      n_cmp++;
      if ({obs_re[i], obs_im[i], obs_last[i]} !== {exp_re[i], exp_im[i], exp_last[i]}) begin
        n_fail++;
        $display("FAIL toggle_beat[%0d]: got re=%0d im=%0d last=%0d want re=%0d im=%0d last=%0d",
                 i, obs_re[i], obs_im[i], obs_last[i], exp_re[i], exp_im[i], exp_last[i]);
      end
    end
  endtask

`ifdef STREAM_BITREV_BYPASS_EN
  task automatic test_bypass();
    logic [DW-1:0] fre [N];
    logic [DW-1:0] fim [N];
    logic [DW-1:0] f2_32;
    clear_queues();
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin fre[k] = DW'(k); fim[k] = DW'(k + 100); end
    send_frame(fre, fim, 1'b1, 0);
    rand_frame(fre, fim);
    f2_32 = fre[32];
    send_frame(fre, fim, 1'b0, 0);
    wait_drain(2 * N);
    n_cmp++; if (obs_re.size() !== 2 * N) begin n_fail++; $display("FAIL bypass_count: got %0d want %0d", obs_re.size(), 2 * N); end
    for (int i = 0; i < exp_re.size() && i < obs_re.size(); i++) begin
      n_cmp++;
      if ({obs_re[i], obs_im[i], obs_last[i]} !== {exp_re[i], exp_im[i], exp_last[i]}) begin
        n_fail++;
        $display("FAIL bypass_beat[%0d]: got re=%0d im=%0d last=%0d want re=%0d im=%0d last=%0d",
                 i, obs_re[i], obs_im[i], obs_last[i], exp_re[i], exp_im[i], exp_last[i]);
      end
    end
    if (obs_re.size() >= 2 * N) begin
      n_cmp++; if ({obs_re[1], obs_re[N+1]} !== {16'd1, f2_32}) begin
        n_fail++; $display("FAIL bypass_order: got %0d,%0d want 1,%0d", obs_re[1], obs_re[N+1], f2_32);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_reset_midframe();
    test_toggle_ready();
`ifdef STREAM_BITREV_BYPASS_EN
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_bitrev_router.md
STREAM_BITREV_ROUTER -- requirements
Module: stream_bitrev_router

Interface
REQ-001 SHALL have parameter N_POINTS, default 64, FFT frame length; legal values are powers of two from 4 to 1024.
REQ-002 SHALL have parameter LOG2_N, default 6, log2(N_POINTS); any mismatch is an elaboration error.
REQ-003 SHALL have parameter DATA_W, default 16, width of each of the re and im parts.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: input sample valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept an input sample.
REQ-008 SHALL have ports in_re and in_im, input, DATA_W bits each: input sample, natural order.
REQ-009 SHALL have port out_valid, output, 1 bit: output sample valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the output sample.
REQ-011 SHALL have ports out_re and out_im, output, DATA_W bits each: output sample, bit-reversed order.
REQ-012 SHALL have port out_last, output, 1 bit: high on the final sample of an output frame.

Function
REQ-013 SHALL transfer an input beat when in_valid and in_ready are both high on a clk edge, and an output beat when out_valid and out_ready are both high.
REQ-014 SHALL hold two banks (ping-pong), each with N_POINTS complex entries; each bank state is EMPTY, FILLING or FULL.
REQ-015 SHALL write input beat k of a frame, k = 0..N_POINTS-1, to entry k of the current write bank.
REQ-016 SHALL mark the write bank FULL on the beat with k = N_POINTS-1, then toggle the write bank and wrap wr_cnt to 0.
REQ-017 SHALL drive in_ready high exactly when the current write bank is not FULL.
REQ-018 SHALL drive out_valid high exactly when the current read bank is FULL.
REQ-019 SHALL drive out_re and out_im from entry bitrev_LOG2N(rd_cnt) of the read bank, combinationally from the registered array; for N=64, rd_cnt 1 reads entry 32.
REQ-020 SHALL assert out_last when out_valid is high and rd_cnt = N_POINTS-1; on that beat it SHALL mark the read bank EMPTY, toggle the read bank and wrap rd_cnt to 0.
REQ-021 SHALL hold out_valid high and out_re, out_im and out_last stable while out_ready is low.
REQ-022 SHALL raise out_valid in the cycle after the last input beat of a frame, when the other bank is not still draining; minimum frame latency is N_POINTS+1 cycles from the first input beat to the first output beat.
REQ-023 SHALL sustain one beat per cycle in each direction at the same time, so N_POINTS-beat frames stream back to back with no bubbles while out_ready stays high.
REQ-024 SHALL handle both banks FULL: in_ready low, no write, no data lost.
REQ-025 SHALL process a write that completes one bank and a read that empties the other bank on the same edge with both state updates taking effect.

Reset
REQ-026 SHALL, while rst is high, set both banks EMPTY, wr_cnt=0, rd_cnt=0, write bank=0 and read bank=0.
REQ-027 SHALL, while rst is high, drive in_ready=0, out_valid=0 and out_last=0; in_ready SHALL rise in the first cycle after rst falls.
REQ-028 SHALL discard a partial frame when reset is asserted mid-frame; stored sample contents need not be cleared.

Configuration
REQ-029 SHALL, when macro STREAM_BITREV_BYPASS_EN is defined, add input port bypass (1 bit), sampled at the first beat of each input frame and carried with that frame's bank.
REQ-030 SHALL, with STREAM_BITREV_BYPASS_EN defined, output a frame flagged bypass in natural order (entry rd_cnt), with identical timing.
REQ-031 SHALL, without STREAM_BITREV_BYPASS_EN, have no bypass port and always output bit-reversed order.

Structure
REQ-032 SHALL place the complex sample struct typedef (re and im, each DATA_W) and the bank-state enum in shared package fft_pkg.
REQ-033 SHALL place the function bitrev(value, LOG2_N) in fft_pkg.
REQ-034 SHALL use one sub-module, bitrev_bank, holding one N_POINTS-entry register bank with a write port and an async read port, instantiated twice.

Verification
REQ-035 SHALL cover: N=64, one frame with re=im=k, out_ready always high -> output sequence 0,32,16,48,8,... ; out_last on beat 63, whose value is 63; first out_valid 65 cycles after the first input beat.
REQ-036 SHALL cover: three frames back to back, out_ready high -> in_ready never drops; outputs continuous from cycle 65 on.
REQ-037 SHALL cover: out_ready held low after two full frames -> in_ready=0 and out_valid=1; the 3rd frame stalls; after release, frames 1 and 2 output intact in bit-reversed order.
REQ-038 SHALL cover: rst pulsed after 20 input beats -> out_valid stays 0; the next full frame outputs correctly.
REQ-039 SHALL cover: out_ready toggled every cycle -> outputs stable across stalls; no loss or duplication (compare against a scoreboard).
REQ-040 SHALL cover: STREAM_BITREV_BYPASS_EN defined, bypass=1 on frame 1 and 0 on frame 2 -> frame 1 output 0,1,2,...; frame 2 output bit-reversed.
